dht_frame_rx: RTL and testbench

- Single-wire protocol engine for DHT11-class humidity/temperature sensors. It is the upstream stage feeding the sensor-value bus of the temperature top level.
- Periodically issues the host start pulse, times the sensor response and 40 data bits, and verifies the checksum.
- Publishes integral humidity and temperature bytes with a valid strobe and sticky error flags.
- Downstream, BCD conversion and the LED matrix consume the output registers directly.

---
 rtl/dht_frame_rx.sv | 217 +++++++++++++++++++++
 tb/tb_dht_frame_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_frame_rx.sv
// dht_frame_rx: periodic DHT11-class single-wire frame receiver with checksum verification.
// Optional `DHT_GLITCH_FILTER_EN adds a 3-tap majority filter behind the line synchronizer.
module dht_frame_rx #(
    parameter int unsigned MAIN_CLK      = 27_000_000,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PERIOD_MS     = 2000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned BIT_THRESH_US = 48,
    parameter int unsigned TIMEOUT_US    = 120,
    parameter bit          USE_CHECKSUM  = 1'b1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    output logic [DATA_BITS-1:0] out_humid,
    output logic [DATA_BITS-1:0] out_temp,
    output logic                 out_valid,
    output logic                 out_busy,
    output logic                 out_err_timeout,
    output logic                 out_err_checksum,
    inout  wire                  inout_dat
);

    localparam longint unsigned TICKS_US      = 64'(MAIN_CLK) / 64'd1_000_000;
    localparam longint unsigned PERIOD_TICKS  = TICKS_US * 64'd1000 * 64'(PERIOD_MS);
    localparam longint unsigned START_TICKS   = TICKS_US * 64'(START_LOW_US);
    localparam longint unsigned THRESH_TICKS  = TICKS_US * 64'(BIT_THRESH_US);
    localparam longint unsigned TIMEOUT_TICKS = TICKS_US * 64'(TIMEOUT_US);
    localparam longint unsigned PH_MAX_A      = (START_TICKS > TIMEOUT_TICKS) ? START_TICKS : TIMEOUT_TICKS;
    localparam longint unsigned PH_MAX        = (PH_MAX_A > THRESH_TICKS) ? PH_MAX_A : THRESH_TICKS;
    localparam int unsigned     PW            = $clog2(PERIOD_TICKS + 64'd1);
    localparam int unsigned     PHW           = $clog2(PH_MAX + 64'd2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_RESP,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PW-1:0]          r_period_cnt;
    logic [PHW-1:0]         r_phase_cnt;
    logic [1:0]             r_sync;
    logic                   r_line_q;
    logic [5:0]             r_bit_idx;
    logic [39:0]            r_shift;
    logic [DATA_BITS-1:0]   r_humid;
    logic [DATA_BITS-1:0]   r_temp;
    logic                   r_valid;
    logic                   r_err_timeout;
    logic                   r_err_checksum;

    logic                   w_line;
    logic                   w_fall;
    logic                   w_rise;
    logic                   w_wrap;
    logic                   w_launch;
    logic                   w_timeout;
    logic                   w_shift_en;
    logic                   w_bit;
    logic [7:0]             w_sum;
    logic                   w_sum_ok;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], inout_dat};
        end
    end

`ifdef DHT_GLITCH_FILTER_EN
    logic [1:0] r_tap;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_tap <= 2'b11;
        end else begin
            r_tap <= {r_tap[0], r_sync[1]};
        end
    end

    assign w_line = (r_sync[1] & r_tap[0]) | (r_sync[1] & r_tap[1]) | (r_tap[0] & r_tap[1]);
`else
    assign w_line = r_sync[1];
`endif

    // Edges rather than levels: the synchronizer still holds our own start-low
    // for a few cycles after release, which must not look like a sensor response.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_line_q <= 1'b1;
        end else begin
            r_line_q <= w_line;
        end
    end

    assign w_fall   = r_line_q & ~w_line;
    assign w_rise   = ~r_line_q & w_line;
    assign w_wrap   = (r_period_cnt == PW'(PERIOD_TICKS - 64'd1));
    assign w_launch = w_wrap & in_enable & (r_state == S_IDLE);
    assign w_bit    = (r_phase_cnt > PHW'(THRESH_TICKS));
    assign w_sum    = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_sum_ok = (w_sum == r_shift[7:0]) || !USE_CHECKSUM;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_period_cnt <= '0;
        end else if (w_wrap) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        w_shift_en   = 1'b0;
        if ((r_state inside {S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH})
            && (r_phase_cnt >= PHW'(TIMEOUT_TICKS))) begin
            w_timeout    = 1'b1;
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      if (w_launch) w_state_next = S_START_LOW;
                S_START_LOW: if (r_phase_cnt >= PHW'(START_TICKS - 64'd1)) w_state_next = S_WAIT_RESP;
                S_WAIT_RESP: if (w_fall) w_state_next = S_RESP_LOW;
                S_RESP_LOW:  if (w_rise) w_state_next = S_RESP_HIGH;
                S_RESP_HIGH: if (w_fall) w_state_next = S_BIT_LOW;
                S_BIT_LOW:   if (w_rise) w_state_next = S_BIT_HIGH;
                S_BIT_HIGH: begin
                    if (w_fall) begin
                        w_shift_en   = 1'b1;
                        w_state_next = (r_bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                    end
                end
                S_CHECK:     w_state_next = S_IDLE;
                default:     w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_phase_cnt <= '0;
        end else if (r_state != w_state_next) begin
            r_phase_cnt <= '0;
        end else if (r_phase_cnt != '1) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (r_state == S_RESP_HIGH && w_state_next == S_BIT_LOW) begin
            r_bit_idx <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {r_shift[38:0], w_bit};
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_humid        <= '0;
            r_temp         <= '0;
            r_valid        <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_checksum <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_launch) begin
                r_err_timeout  <= 1'b0;
                r_err_checksum <= 1'b0;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
            // Data and strobe are registered together so out_valid always frames the new values.
            if (r_state == S_CHECK) begin
                if (w_sum_ok) begin
                    r_humid <= DATA_BITS'(r_shift[39:32]);
                    r_temp  <= DATA_BITS'(r_shift[23:16]);
                    r_valid <= 1'b1;
                end else begin
                    r_err_checksum <= 1'b1;
                end
            end
        end
    end

    assign inout_dat        = (r_state == S_START_LOW) ? 1'b0 : 1'bz;
    assign out_busy         = (r_state != S_IDLE);
    assign out_humid        = r_humid;
    assign out_temp         = r_temp;
    assign out_valid        = r_valid;
    assign out_err_timeout  = r_err_timeout;
    assign out_err_checksum = r_err_checksum;

endmodule

// File: tb/tb_dht_frame_rx.sv
// tb_dht_frame_rx: directed bench for dht_frame_rx with a behavioural DHT sensor on a pulled-up line.
module tb_dht_frame_rx;

    localparam int PERIOD    = 5000;
    localparam int START_LOW = 500;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic       sens_low = 1'b0;
    wire        w_dat;
    logic [7:0] humid;
    logic [7:0] temp;
    logic       valid;
    logic       busy;
    logic       err_to;
    logic       err_cs;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    pullup (w_dat);
    assign w_dat = sens_low ? 1'b0 : 1'bz;

    dht_frame_rx #(
        .MAIN_CLK     (1_000_000),
        .DATA_BITS    (8),
        .PERIOD_MS    (5),
        .START_LOW_US (START_LOW),
        .BIT_THRESH_US(48),
        .TIMEOUT_US   (120),
        .USE_CHECKSUM (1'b1)
    ) dut (
        .in_clk          (clk),
        .in_rst          (rst_n),
        .in_enable       (en),
        .out_humid       (humid),
        .out_temp        (temp),
        .out_valid       (valid),
        .out_busy        (busy),
        .out_err_timeout (err_to),
        .out_err_checksum(err_cs),
        .inout_dat       (w_dat)
    );

    always @(negedge clk) if (valid) valid_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int limit, output int n);
        n = 0;
        while (busy !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drive(input logic lvl, input int us);
        sens_low = ~lvl;
        repeat (us) @(negedge clk);
    endtask

    task automatic finish_frame(input string tag);
        int n;
        wait_busy(1'b0, 2 * PERIOD, n);
        check({tag, "_busy_fall"}, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic sensor_frame(input logic [39:0] data, input int glitch_bit,
                                input int abort_bit, input bit drop_en);
        int n;
        n = 0;
        while (w_dat !== 1'b0 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("host_start_seen", w_dat, 1'b0);
        if (w_dat !== 1'b0) return;
        n = 0;
        while (w_dat === 1'b0 && n < 2 * START_LOW) begin
            @(negedge clk);
            n++;
        end
        check("start_low_len", n, START_LOW);
        drive(1'b1, 30);
        drive(1'b0, 80);
        drive(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            if (i == abort_bit) begin
                sens_low = 1'b0;
                rst_n    = 1'b0;
                #1;
                check("abort_humid", humid, 8'h00);
                check("abort_temp", temp, 8'h00);
                check("abort_busy", busy, 1'b0);
                check("abort_valid", valid, 1'b0);
                check("abort_err_cs", err_cs, 1'b0);
                check("abort_line_released", w_dat, 1'b1);
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (drop_en && i == 10) en = 1'b0;
            drive(1'b0, 50);
            if (data[39-i]) begin
                if (i == glitch_bit) begin
                    drive(1'b1, 30);
                    drive(1'b0, 1);
                    drive(1'b1, 39);
                end else begin
                    drive(1'b1, 70);
                end
            end else begin
                drive(1'b1, 27);
            end
        end
        drive(1'b0, 50);
        sens_low = 1'b0;
    endtask

    initial begin
        #(100_000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int busy_cycles;
        int low_cycles;

        repeat (3) @(negedge clk);
        check("rst_humid", humid, 8'h00);
        check("rst_temp", temp, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_to", err_to, 1'b0);
        check("rst_err_cs", err_cs, 1'b0);
        check("rst_line", w_dat, 1'b1);

        en    = 1'b1;
        rst_n = 1'b1;
        wait_busy(1'b1, 2 * PERIOD, n);
        check("first_launch", n, PERIOD);

        // Good frame
        base = valid_cnt;
        sensor_frame(40'h37_00_19_00_50, -1, -1, 1'b0);
        finish_frame("A");
        check("A_valid_cnt", valid_cnt - base, 1);
        check("A_humid", humid, 8'h37);
        check("A_temp", temp, 8'h19);
        check("A_err_to", err_to, 1'b0);
        check("A_err_cs", err_cs, 1'b0);

        // Bad checksum
        base = valid_cnt;
        sensor_frame(40'h37_00_19_00_51, -1, -1, 1'b0);
        finish_frame("B");
        check("B_valid_cnt", valid_cnt - base, 0);
        check("B_humid", humid, 8'h37);
        check("B_temp", temp, 8'h19);
        check("B_err_cs", err_cs, 1'b1);
        check("B_err_to", err_to, 1'b0);

        // No sensor: 500 start-low cycles plus a 121-cycle response timeout
        base = valid_cnt;
        wait_busy(1'b1, 2 * PERIOD, n);
        check("C_launch", busy, 1'b1);
        check("C_err_cs_cleared", err_cs, 1'b0);
        wait_busy(1'b0, 2 * PERIOD, n);
        check("C_busy_len", n, START_LOW + 121);
        check("C_err_to", err_to, 1'b1);
        check("C_err_cs", err_cs, 1'b0);
        check("C_valid_cnt", valid_cnt - base, 0);

        // Next frame clears the timeout; enable drops mid-frame
        wait_busy(1'b1, 2 * PERIOD, n);
        check("D_err_to_cleared", err_to, 1'b0);
        base = valid_cnt;
        sensor_frame(40'h42_00_1A_00_5C, -1, -1, 1'b1);
        finish_frame("D");
        check("D_valid_cnt", valid_cnt - base, 1);
        check("D_humid", humid, 8'h42);
        check("D_temp", temp, 8'h1A);

        // Disabled across a period wrap
        busy_cycles = 0;
        low_cycles  = 0;
        repeat (PERIOD + 200) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (w_dat !== 1'b1) low_cycles++;
        end
        check("skip_busy_cycles", busy_cycles, 0);
        check("skip_line_low_cycles", low_cycles, 0);
        en = 1'b1;

        // One-cycle low spike 30 us into the high phase of bit 2 (a '1')
        base = valid_cnt;
        sensor_frame(40'h37_00_19_00_50, 2, -1, 1'b0);
        finish_frame("E");
        check("E_err_to", err_to, 1'b0);
`ifdef DHT_GLITCH_FILTER_EN
        check("E_valid_cnt", valid_cnt - base, 1);
        check("E_humid", humid, 8'h37);
        check("E_err_cs", err_cs, 1'b0);
`else
        check("E_valid_cnt", valid_cnt - base, 0);
        check("E_humid", humid, 8'h42);
        check("E_err_cs", err_cs, 1'b1);
`endif

        // Reset at bit 20, then a full new frame
        sensor_frame(40'h37_00_19_00_50, -1, 20, 1'b0);
        base = valid_cnt;
        wait_busy(1'b1, 2 * PERIOD, n);
        check("relaunch_latency", n, PERIOD);
        check("no_valid_after_reset", valid_cnt - base, 0);
        sensor_frame(40'h37_00_19_00_50, -1, -1, 1'b0);
        finish_frame("G");
        check("G_valid_cnt", valid_cnt - base, 1);
        check("G_humid", humid, 8'h37);
        check("G_temp", temp, 8'h19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
